// File: rtl/prbs_ctrl_pkg.sv
// Shared types and constants for the PRBS test controller.
package prbs_ctrl_pkg;

  localparam int BYTE_W            = 8;
  localparam int BYTES_PER_PATTERN = 4;
  localparam int PATTERN_W         = BYTE_W * BYTES_PER_PATTERN;
  localparam int DP_RST_CYCLES     = 2;
  localparam int RST_CNT_W         = 2;
  localparam int IDX_W             = 2;
  localparam int TMR_W             = 8;
  localparam int CNT_W             = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DP_RESET = 3'd1,
    S_LOAD     = 3'd2,
    S_WAIT     = 3'd3,
    S_REPORT   = 3'd4
  } state_t;

  // Byte idx of a pattern, counted from the most significant byte.
  function automatic logic [BYTE_W-1:0] pattern_byte(
    input logic [PATTERN_W-1:0] p,
    input logic [IDX_W-1:0]     idx
  );
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = p[31:24];
      2'd1:    b = p[23:16];
      2'd2:    b = p[15:8];
      2'd3:    b = p[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs_ctrl_timer.sv
// Wait-window timer: counts value+1 enabled cycles after a load.
// final_cycle marks the last enabled cycle of the window so the caller
// can decide on that same edge; expired is the registered end flag.
module prbs_ctrl_timer
  import prbs_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [TMR_W-1:0] value,
  output logic             expired,
  output logic             final_cycle
);

  logic [TMR_W-1:0] count;

  // Count down the loaded window and latch expiry after the last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= TMR_W'(0);
      expired <= 1'b0;
    end else if (load) begin
      count   <= value;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      if (count == TMR_W'(0)) begin
        expired <= 1'b1;
      end else begin
        count <= count - TMR_W'(1);
      end
    end
  end

  assign final_cycle = enable && !expired && (count == TMR_W'(0));

endmodule

// File: rtl/prbs_test_ctrl.sv
// PRBS test controller: resets the PRBS datapath, streams a four-byte
// pattern MSB first, then waits a bounded window for the detector flag
// and reports pass/fail with a one-cycle done pulse.
// Optional build macro PRBS_CTRL_STATS_EN adds saturating pass/fail counters.
module prbs_test_ctrl
  import prbs_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [BYTE_W-1:0]    n_repeat,
  input  logic [TMR_W-1:0]     timeout,
  input  logic                 pattern_found,
  output logic                 dp_rst,
  output logic [BYTE_W-1:0]    dp_in,
  output logic [BYTE_W-1:0]    dp_n_pattern,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail
`ifdef PRBS_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt
`endif
);

  state_t                 state;
  logic [PATTERN_W-1:0]   pattern_q;
  logic [TMR_W-1:0]       timeout_q;
  logic [IDX_W-1:0]       byte_idx;
  logic [RST_CNT_W-1:0]   rst_cnt;
  logic                   tmr_load;
  logic                   tmr_enable;
  logic                   tmr_expired;
  logic                   tmr_final;

  // The window starts on the edge that leaves the last LOAD byte.
  assign tmr_load   = (state == S_LOAD) && (byte_idx == IDX_W'(BYTES_PER_PATTERN - 1));
  assign tmr_enable = (state == S_WAIT);

  prbs_ctrl_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (tmr_load),
    .enable      (tmr_enable),
    .value       (timeout_q),
    .expired     (tmr_expired),
    .final_cycle (tmr_final)
  );

  // Test sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pattern_q    <= {PATTERN_W{1'b0}};
      timeout_q    <= TMR_W'(0);
      byte_idx     <= IDX_W'(0);
      rst_cnt      <= RST_CNT_W'(0);
      dp_rst       <= 1'b0;
      dp_in        <= 8'h00;
      dp_n_pattern <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          dp_rst <= 1'b1;
          if (start) begin
            pass <= 1'b0;
            fail <= 1'b0;
            busy <= 1'b1;
            if (n_repeat != 8'd0) begin
              pattern_q    <= pattern;
              timeout_q    <= timeout;
              dp_n_pattern <= n_repeat;
              dp_rst       <= 1'b0;
              rst_cnt      <= RST_CNT_W'(0);
              state        <= S_DP_RESET;
            end else begin
              // Illegal repeat count: report failure without touching the datapath.
              fail  <= 1'b1;
              done  <= 1'b1;
              state <= S_REPORT;
            end
          end
        end
        S_DP_RESET: begin
          if (rst_cnt == RST_CNT_W'(DP_RST_CYCLES - 1)) begin
            dp_rst   <= 1'b1;
            byte_idx <= IDX_W'(0);
            dp_in    <= pattern_byte(pattern_q, IDX_W'(0));
            state    <= S_LOAD;
          end else begin
            rst_cnt <= rst_cnt + RST_CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (byte_idx == IDX_W'(BYTES_PER_PATTERN - 1)) begin
            state <= S_WAIT;
          end else begin
            byte_idx <= byte_idx + IDX_W'(1);
            dp_in    <= pattern_byte(pattern_q, byte_idx + IDX_W'(1));
          end
        end
        S_WAIT: begin
          if (pattern_found) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= S_REPORT;
          end else if (tmr_final || tmr_expired) begin
            fail  <= 1'b1;
            done  <= 1'b1;
            state <= S_REPORT;
          end else begin
            state <= S_WAIT;
          end
        end
        S_REPORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PRBS_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Tally finished runs by result, saturating at the counter maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= CNT_W'(0);
      fail_cnt <= CNT_W'(0);
    end else begin
      if (done && pass && (pass_cnt != CNT_MAX)) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end
      if (done && fail && (fail_cnt != CNT_MAX)) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
